reg_spill_fill: RTL

- Sequencer on the opposite side of the register file ports: it drives the read index and write port and moves register contents to and from data memory.
- Spill: reads a masked set of registers and stores them to consecutive memory words.
- Fill: loads consecutive memory words and writes them back into the masked registers.
- Used for call/interrupt context save and restore; sits between the control unit, the register file and the memory arbiter.

---
 rtl/reg_spill_fill_pkg.sv | 20 ++
 rtl/reg_mask_prio_enc.sv | 19 +
 rtl/reg_spill_fill.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/reg_spill_fill_pkg.sv
// Shared types and defaults for the register spill/fill engine.
package reg_spill_fill_pkg;

  localparam int DATA_W_DEF = 19;
  localparam int ADDR_W_DEF = 16;
  localparam int IDX_W_DEF  = 4;

  localparam logic MODE_SPILL = 1'b0;
  localparam logic MODE_FILL  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_SPILL_WR,
    S_FILL_RD,
    S_FILL_WB,
    S_DONE
  } state_e;

endpackage

// File: rtl/reg_mask_prio_enc.sv
// Lowest-set-bit priority encoder over the pending register mask.
module reg_mask_prio_enc #(
  parameter int IDX_W = 4
) (
  input  logic [2**IDX_W-1:0] mask_i,
  output logic [IDX_W-1:0]    idx_o,
  output logic                any_o
);

  always_comb begin
    idx_o = '0;
    any_o = |mask_i;
    // Descending scan so the lowest set bit is the last one to win.
    for (int i = 2**IDX_W - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reg_spill_fill.sv
// Spill/fill sequencer moving masked registers to and from consecutive
// memory words for context save and restore.
module reg_spill_fill
  import reg_spill_fill_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [2**IDX_W-1:0] mask,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic [IDX_W:0]      xfer_count,
  output logic [IDX_W-1:0]    rf_read_index,
  input  logic [DATA_W-1:0]   rf_read_data,
  output logic                rf_we,
  output logic [IDX_W-1:0]    rf_write_index,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  localparam int NREG = 2**IDX_W;
  localparam logic [NREG-1:0] ONE = NREG'(1);

  state_e              state_q, state_d;
  logic [NREG-1:0]     mask_q, mask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mode_q, mode_d;
  logic [IDX_W:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]    cur_q, cur_d;
  logic [DATA_W-1:0]   buf_q, buf_d;

  logic [IDX_W-1:0]    enc_idx;
  logic                enc_any;
  logic [NREG-1:0]     cur_bit;

  reg_mask_prio_enc #(
    .IDX_W(IDX_W)
  ) u_enc (
    .mask_i(mask_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign cur_bit    = ONE << cur_q;
  assign xfer_count = cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      cur_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    mask_d         = mask_q;
    addr_d         = addr_q;
    mode_d         = mode_q;
    cnt_d          = cnt_q;
    cur_d          = cur_q;
    buf_d          = buf_q;
    busy           = 1'b0;
    done           = 1'b0;
    rf_read_index  = '0;
    rf_we          = 1'b0;
    rf_write_index = '0;
    rf_write_data  = '0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_we         = 1'b0;
    mem_re         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d  = mask & ~ONE;
          addr_d  = base_addr;
          mode_d  = mode;
          cnt_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        busy = 1'b1;
        if (!enc_any) begin
          state_d = S_DONE;
        end else begin
          cur_d   = enc_idx;
          state_d = (mode_q == MODE_FILL) ? S_FILL_RD : S_SPILL_WR;
        end
      end
      S_SPILL_WR: begin
        busy          = 1'b1;
        rf_read_index = cur_q;
        mem_we        = 1'b1;
        mem_addr      = addr_q;
        mem_wdata     = rf_read_data;
        if (mem_ready) begin
          mask_d  = mask_q & ~cur_bit;
          addr_d  = addr_q + ADDR_W'(1);
          cnt_d   = cnt_q + (IDX_W+1)'(1);
          state_d = S_SCAN;
        end
      end
      S_FILL_RD: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = addr_q;
        if (mem_ready) begin
          buf_d   = mem_rdata;
          state_d = S_FILL_WB;
        end
      end
      S_FILL_WB: begin
        busy           = 1'b1;
        rf_we          = 1'b1;
        rf_write_index = cur_q;
        rf_write_data  = buf_q;
        mask_d         = mask_q & ~cur_bit;
        addr_d         = addr_q + ADDR_W'(1);
        cnt_d          = cnt_q + (IDX_W+1)'(1);
        state_d        = S_SCAN;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
